// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready load and framing strobes.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             d_out,
  output logic             busy,
  output logic             frame_start,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE,
    SHIFT
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             fs_q, fs_d;
  logic             wd_q, wd_d;
  logic             rdy_raw;
  logic             accept;
  logic [CW-1:0]    nxt;

  // Bit n of the stream, in the configured shift order.
  function automatic logic bit_at(
    input logic [WIDTH-1:0] w,
    input logic [CW-1:0]    n
  );
    logic b;
    if (MSB_FIRST) b = w[LAST - n];
    else           b = w[n];
    return b;
  endfunction

  always_comb begin
    rdy_raw = 1'b0;
    unique case (state_q)
      IDLE:   rdy_raw = 1'b1;
`ifdef PISO_PARITY_EN
      SHIFT:  rdy_raw = 1'b0;
      PARITY: rdy_raw = 1'b1;
`else
      SHIFT:  rdy_raw = (cnt_q == LAST);
`endif
      default: rdy_raw = 1'b0;
    endcase
  end

  assign load_ready = rdy_raw & ~reset;
  assign accept     = load_valid & load_ready;
  assign nxt        = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    dout_d  = 1'b0;
    busy_d  = 1'b0;
    fs_d    = 1'b0;
    wd_d    = 1'b0;
    if (accept) begin
      // Accept also covers the back-to-back restart on the last frame cycle.
      state_d = SHIFT;
      cnt_d   = '0;
      word_d  = din;
      dout_d  = bit_at(din, '0);
      busy_d  = 1'b1;
      fs_d    = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SHIFT: begin
          if (cnt_q != LAST) begin
            cnt_d  = nxt;
            dout_d = bit_at(word_q, nxt);
            busy_d = 1'b1;
`ifndef PISO_PARITY_EN
            wd_d   = (nxt == LAST);
`endif
          end else begin
            cnt_d = '0;
`ifdef PISO_PARITY_EN
            state_d = PARITY;
            dout_d  = ^word_q;
            busy_d  = 1'b1;
            wd_d    = 1'b1;
`else
            state_d = IDLE;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          state_d = IDLE;
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      fs_q    <= 1'b0;
      wd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      fs_q    <= fs_d;
      wd_q    <= wd_d;
    end
  end

  assign d_out       = dout_q;
  assign busy        = busy_q;
  assign frame_start = fs_q;
  assign word_done   = wd_q;

endmodule
